// File: rtl/capture_sequencer.sv
// capture_sequencer: controls one logic-analyser capture run.
// Evaluates a mask/value trigger on incoming samples and drives the write
// port of an external circular sample RAM: pre-trigger history wraps until
// the trigger fires, then post_count further samples are written and the
// run stops, reporting the RAM address of the trigger sample.
//
// Optional build macro TRIG_EDGE_EN adds a trig_edge input that also
// requires a change on selected bits relative to the previous valid sample.
module capture_sequencer #(
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [AW-1:0]    post_count,
`ifdef TRIG_EDGE_EN
  input  logic [WIDTH-1:0] trig_edge,
`endif
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW-1:0]    trig_addr,
  output logic             wrapped,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0]    AW_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]    AW_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    AW_MAX  = {AW{1'b1}};
  localparam logic [WIDTH-1:0] W_ZERO  = {WIDTH{1'b0}};

  state_t           r_state;
  logic [WIDTH-1:0] r_trig_mask;
  logic [WIDTH-1:0] r_trig_value;
  logic [AW-1:0]    r_post_cfg;
  logic [AW-1:0]    r_post_cnt;
  logic [AW-1:0]    r_ptr;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic [AW-1:0]    r_trig_addr;
  logic             r_wrapped;
  logic             r_busy;
  logic             r_done;
`ifdef TRIG_EDGE_EN
  logic [WIDTH-1:0] r_trig_edge;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_valid;
`endif

  logic             w_level_match;
  logic             w_edge_ok;
  logic             w_match;
  logic [AW-1:0]    w_ptr_inc;
  logic             w_ptr_wraps;

  // Trigger evaluation on the current sample against the latched config.
  always_comb begin
    w_level_match = 1'b0;
    w_edge_ok     = 1'b1;
    w_ptr_inc     = r_ptr + AW_ONE;
    w_ptr_wraps   = (r_ptr == AW_MAX);
    if (((sample ^ r_trig_value) & r_trig_mask) == W_ZERO) begin
      w_level_match = 1'b1;
    end else begin
      w_level_match = 1'b0;
    end
`ifdef TRIG_EDGE_EN
    // Without a previous sample no edge can be seen, so only an empty
    // edge selection is satisfied on the first sample after arm.
    if (r_prev_valid) begin
      w_edge_ok = (((sample ^ r_prev) & r_trig_edge) == r_trig_edge);
    end else begin
      w_edge_ok = (r_trig_edge == W_ZERO);
    end
`else
    w_edge_ok = 1'b1;
`endif
    w_match = w_level_match & w_edge_ok;
  end

  // Run-control FSM with write path, trigger capture and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_trig_mask  <= W_ZERO;
      r_trig_value <= W_ZERO;
      r_post_cfg   <= AW_ZERO;
      r_post_cnt   <= AW_ZERO;
      r_ptr        <= AW_ZERO;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= AW_ZERO;
      r_wr_data    <= W_ZERO;
      r_trig_addr  <= AW_ZERO;
      r_wrapped    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef TRIG_EDGE_EN
      r_trig_edge  <= W_ZERO;
      r_prev       <= W_ZERO;
      r_prev_valid <= 1'b0;
`endif
    end else begin
      // The strobe only stays high on cycles that actually write.
      r_wr_en <= 1'b0;
      if (abort) begin
        // Pointer, trigger address and wrap flag are kept for inspection.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              r_trig_mask  <= trig_mask;
              r_trig_value <= trig_value;
              r_post_cfg   <= post_count;
              r_ptr        <= AW_ZERO;
              r_wr_addr    <= AW_ZERO;
              r_wrapped    <= 1'b0;
              r_state      <= S_ARMED;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
`ifdef TRIG_EDGE_EN
              r_trig_edge  <= trig_edge;
              r_prev       <= W_ZERO;
              r_prev_valid <= 1'b0;
`endif
            end else begin
              r_state <= r_state;
            end
          end
          S_ARMED: begin
            if (sample_valid) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= sample;
              r_ptr     <= w_ptr_inc;
              if (w_ptr_wraps) begin
                r_wrapped <= 1'b1;
              end else begin
                r_wrapped <= r_wrapped;
              end
`ifdef TRIG_EDGE_EN
              r_prev       <= sample;
              r_prev_valid <= 1'b1;
`endif
              if (w_match) begin
                r_trig_addr <= r_ptr;
                r_post_cnt  <= r_post_cfg;
                if (r_post_cfg == AW_ZERO) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_POST;
                end
              end else begin
                r_state <= S_ARMED;
              end
            end else begin
              r_state <= S_ARMED;
            end
          end
          S_POST: begin
            if (sample_valid) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_ptr;
              r_wr_data  <= sample;
              r_ptr      <= w_ptr_inc;
              r_post_cnt <= r_post_cnt - AW_ONE;
              if (w_ptr_wraps) begin
                r_wrapped <= 1'b1;
              end else begin
                r_wrapped <= r_wrapped;
              end
              // The sample taking the counter from 1 to 0 is the last one.
              if (r_post_cnt <= AW_ONE) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_POST;
              end
            end else begin
              r_state <= S_POST;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign trig_addr = r_trig_addr;
  assign wrapped   = r_wrapped;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer (AW=4 so wrap is reachable).
// Expected RAM writes are queued by the stimulus; a monitor compares them
// against the write port whenever wr_en is seen high.
module tb_capture_sequencer;

  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst;
  logic             arm;
  logic             abort;
  logic [WIDTH-1:0] trig_mask;
  logic [WIDTH-1:0] trig_value;
  logic [AW-1:0]    post_count;
`ifdef TRIG_EDGE_EN
  logic [WIDTH-1:0] trig_edge;
`endif
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    trig_addr;
  logic             wrapped;
  logic             busy;
  logic             done;

  int n_vec;
  int n_err;
  int exp_addr_q[$];
  int exp_data_q[$];

  capture_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .post_count   (post_count),
`ifdef TRIG_EDGE_EN
    .trig_edge    (trig_edge),
`endif
    .sample       (sample),
    .sample_valid (sample_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .trig_addr    (trig_addr),
    .wrapped      (wrapped),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic send(input logic [WIDTH-1:0] s, input logic v);
    sample       = s;
    sample_valid = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] v,
                        input logic [AW-1:0] pc);
    trig_mask  = m;
    trig_value = v;
    post_count = pc;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    // Scramble config so that any late re-latch would be visible.
    trig_mask  = 16'hFFFF;
    trig_value = 16'hA5A5;
    post_count = 4'd9;
  endtask

  // Monitor: every observed RAM write must match the oldest expected write.
  initial begin
    int ea;
    int ed;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && wr_en === 1'b1) begin
        n_vec++;
        if (exp_addr_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          if (int'(wr_addr) != ea || int'(wr_data) != ed) begin
            n_err++;
            $display("FAIL ram_write: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                     wr_addr, wr_data, ea, ed);
          end
        end
      end
    end
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b0;
    arm          = 1'b0;
    abort        = 1'b0;
    trig_mask    = 16'h0000;
    trig_value   = 16'h0000;
    post_count   = 4'd0;
`ifdef TRIG_EDGE_EN
    trig_edge    = 16'h0000;
`endif
    sample       = 16'h0000;
    sample_valid = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_flags", {29'd0, wrapped, busy, done}, 32'd0);
    rst = 1'b1;
    tick();

    // All-zero mask: fires on the first sample, three post samples.
    do_arm(16'h0000, 16'h0000, 4'd3);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      push_wr(i, 16'h0010 + i);
      send(16'h0010 + 16'(i), 1'b1);
    end
    check("t2_done_end", 32'(done), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_trig_addr", 32'(trig_addr), 32'd0);
    send(16'h0014, 1'b1);
    check("t2_no_write_done", 32'(wr_en), 32'd0);
    send(16'h0015, 1'b1);
    check("t2_done_hold", 32'(done), 32'd1);

    // Wrap then trigger on 0x42 at address 2, one post sample.
    do_arm(16'h00FF, 16'h0042, 4'd1);
    check("t3_done_drops", 32'(done), 32'd0);
    check("t3_wrapped_clr", 32'(wrapped), 32'd0);
    for (int i = 0; i <= 16'h42; i++) begin
      push_wr(i % 16, i);
      send(16'(i), 1'b1);
      if (i == 14) check("t3_wrapped_before", 32'(wrapped), 32'd0);
      if (i == 15) check("t3_wrapped_after", 32'(wrapped), 32'd1);
    end
    check("t3_in_post", {30'd0, busy, done}, 32'd2);
    push_wr(3, 16'h0043);
    send(16'h0043, 1'b1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_trig_addr", 32'(trig_addr), 32'd2);
    check("t3_wrapped", 32'(wrapped), 32'd1);

    // Trigger at 5, post_count 2, valid every other cycle.
    do_arm(16'hFFFF, 16'h0005, 4'd2);
    check("t4_wrapped_clr", 32'(wrapped), 32'd0);
    for (int i = 0; i < 8; i++) begin
      push_wr(i, i);
      send(16'(i), 1'b1);
      check("t4_wr_en_valid", 32'(wr_en), 32'd1);
      if (i == 6) check("t4_done_early", 32'(done), 32'd0);
      send(16'hDEAD, 1'b0);
      check("t4_wr_en_idle", 32'(wr_en), 32'd0);
    end
    check("t4_done", 32'(done), 32'd1);
    check("t4_trig_addr", 32'(trig_addr), 32'd5);

    // post_count 0: trigger sample only, then arm+abort together.
    do_arm(16'hFFFF, 16'h0005, 4'd0);
    for (int i = 0; i < 6; i++) begin
      push_wr(i, i);
      send(16'(i), 1'b1);
      if (i == 4) check("t5_not_done", 32'(done), 32'd0);
    end
    check("t5_done", 32'(done), 32'd1);
    check("t5_trig_addr", 32'(trig_addr), 32'd5);
    send(16'h0006, 1'b1);
    check("t5_no_extra", 32'(wr_en), 32'd0);
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    check("t5_abort_flags", {30'd0, busy, done}, 32'd0);
    check("t5_abort_wr_addr", 32'(wr_addr), 32'd5);
    check("t5_abort_trig_addr", 32'(trig_addr), 32'd5);
    tick();
    check("t5_no_new_run", 32'(busy), 32'd0);
    send(16'h0009, 1'b1);
    check("t5_idle_no_write", 32'(wr_en), 32'd0);

    // Reset while in POST.
    do_arm(16'h0000, 16'h0000, 4'd5);
    push_wr(0, 16'h0020);
    send(16'h0020, 1'b1);
    push_wr(1, 16'h0021);
    send(16'h0021, 1'b1);
    check("t1_busy_post", 32'(busy), 32'd1);
    send(16'h0000, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("t1_rst_wr_en", 32'(wr_en), 32'd0);
    check("t1_rst_addrs", {wr_addr, trig_addr}, 32'd0);
    check("t1_rst_data", 32'(wr_data), 32'd0);
    check("t1_rst_flags", {29'd0, wrapped, busy, done}, 32'd0);
    rst = 1'b1;
    send(16'h0030, 1'b1);
    check("t1_after_rst_wr_en", 32'(wr_en), 32'd0);
    send(16'h0031, 1'b1);
    check("t1_after_rst_busy", 32'(busy), 32'd0);

`ifdef TRIG_EDGE_EN
    // Rising edge on bit 0: samples 1,1,0,1 trigger on the 4th.
    trig_edge = 16'h0001;
    do_arm(16'h0001, 16'h0001, 4'd0);
    trig_edge = 16'h0000;
    push_wr(0, 16'h0001);
    send(16'h0001, 1'b1);
    check("t6_first_no_trig", 32'(done), 32'd0);
    push_wr(1, 16'h0001);
    send(16'h0001, 1'b1);
    push_wr(2, 16'h0000);
    send(16'h0000, 1'b1);
    check("t6_not_yet", 32'(done), 32'd0);
    push_wr(3, 16'h0001);
    send(16'h0001, 1'b1);
    check("t6_done", 32'(done), 32'd1);
    check("t6_trig_addr", 32'(trig_addr), 32'd3);
`endif

    tick();
    tick();
    check("queue_drained", 32'(exp_addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
